// File: rtl/bme280_pkg.sv
// Shared constants for the BME280 bus emulator: device identity, register
// addresses and the I2C responder state encoding.
package bme280_pkg;

  localparam logic [6:0] BME280_SLADDR  = 7'b111_0110;
  localparam logic [7:0] BME280_CHIP_ID = 8'h60;

  localparam logic [7:0] REG_ID        = 8'hD0;
  localparam logic [7:0] REG_RESET     = 8'hE0;
  localparam logic [7:0] REG_CTRL_HUM  = 8'hF2;
  localparam logic [7:0] REG_STATUS    = 8'hF3;
  localparam logic [7:0] REG_CTRL_MEAS = 8'hF4;
  localparam logic [7:0] REG_CONFIG    = 8'hF5;
  localparam logic [7:0] REG_PRESS_MSB = 8'hF7;
  localparam logic [7:0] REG_CALIB00   = 8'h88;
  localparam logic [7:0] REG_CALIB26   = 8'hE1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/bme280_i2c_slave_regfile.sv
// 256x8 register map: host and I2C write ports (host wins on collision),
// asynchronous read port, chip-ID preloaded at reset.
module i2c_slave_regfile #(
  parameter logic [7:0] CHIP_ID = 8'h60,
  parameter logic [7:0] ID_ADDR = 8'hD0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_we,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  input  logic       i2c_we,
  input  logic [7:0] i2c_addr,
  input  logic [7:0] i2c_wdata,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem_q [256];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem_q[i] <= (i[7:0] == ID_ADDR) ? CHIP_ID : 8'h00;
    end else begin
      if (i2c_we) mem_q[i2c_addr] <= i2c_wdata;
      // Later assignment takes precedence, so the host port wins a collision.
      if (host_we) mem_q[host_addr] <= host_wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_reg.sv
// Multi-stage flop synchroniser for asynchronous inputs; resets to RST_VAL so
// idle-high bus lines do not produce a false edge when reset is released.
module sync_reg #(
  parameter int               STAGES  = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= RST_VAL;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/bme280_i2c_slave.sv
// BME280 bus-interface emulator: I2C responder with register pointer,
// data writes and auto-incrementing burst reads over a 256-byte map.
module bme280_i2c_slave
  import bme280_pkg::*;
#(
  parameter logic [6:0] SLADDR  = BME280_SLADDR,
  parameter logic [7:0] CHIP_ID = BME280_CHIP_ID,
  parameter int         NSYNC   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oen,
  input  logic       reg_we,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic       i2c_wr,
  output logic [7:0] i2c_waddr,
  output logic [7:0] i2c_wdata,
  output logic       busy
);

  logic scl_s, sda_s, scl_prev_q, sda_prev_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  i2c_state_e state_q;
  logic [3:0] cnt_q;
  logic [7:0] shift_q, ptr_q, map_rdata;
  logic       rw_q, sda_oen_q, busy_q, i2c_wr_q;
  logic [7:0] i2c_waddr_q, i2c_wdata_q;

  sync_reg #(.STAGES(NSYNC), .WIDTH(2), .RST_VAL(2'b11)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({scl_i, sda_i}),
    .q     ({scl_s, sda_s})
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_rise  =  scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s &  scl_prev_q;
  assign start_det =  scl_s &  scl_prev_q &  sda_prev_q & ~sda_s;
  assign stop_det  =  scl_s &  scl_prev_q & ~sda_prev_q &  sda_s;

  i2c_slave_regfile #(.CHIP_ID(CHIP_ID), .ID_ADDR(REG_ID)) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .host_we    (reg_we),
    .host_addr  (reg_addr),
    .host_wdata (reg_wdata),
    .i2c_we     (i2c_wr_q),
    .i2c_addr   (i2c_waddr_q),
    .i2c_wdata  (i2c_wdata_q),
    .raddr      (ptr_q),
    .rdata      (map_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 8'h00;
      ptr_q       <= 8'h00;
      rw_q        <= 1'b0;
      sda_oen_q   <= 1'b1;
      busy_q      <= 1'b0;
      i2c_wr_q    <= 1'b0;
      i2c_waddr_q <= 8'h00;
      i2c_wdata_q <= 8'h00;
    end else begin
      i2c_wr_q <= 1'b0;
      if (stop_det) begin
        state_q   <= ST_IDLE;
        sda_oen_q <= 1'b1;
        busy_q    <= 1'b0;
        cnt_q     <= 4'd0;
      end else if (start_det) begin
        state_q   <= ST_ADDR;
        sda_oen_q <= 1'b1;
        cnt_q     <= 4'd0;
      end else begin
        case (state_q)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise && cnt_q != 4'd8) begin
              shift_q <= {shift_q[6:0], sda_s};
              cnt_q   <= cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              if (state_q == ST_ADDR) begin
                if (shift_q[7:1] == SLADDR) begin
                  sda_oen_q <= 1'b0;
                  busy_q    <= 1'b1;
                  rw_q      <= shift_q[0];
                  state_q   <= ST_ADDR_ACK;
                end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_WAIT_STOP;
                end
              end else if (state_q == ST_PTR) begin
                ptr_q     <= shift_q;
                sda_oen_q <= 1'b0;
                state_q   <= ST_PTR_ACK;
              end else begin
                i2c_wr_q    <= 1'b1;
                i2c_waddr_q <= ptr_q;
                i2c_wdata_q <= shift_q;
                ptr_q       <= ptr_q + 8'd1;
                sda_oen_q   <= 1'b0;
                state_q     <= ST_WDATA_ACK;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              cnt_q <= 4'd0;
              if (rw_q) begin
                // Latch the whole byte now so later host writes cannot alter it.
                shift_q   <= map_rdata;
                sda_oen_q <= map_rdata[7];
                state_q   <= ST_RDATA;
              end else begin
                sda_oen_q <= 1'b1;
                state_q   <= ST_PTR;
              end
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              sda_oen_q <= 1'b1;
              cnt_q     <= 4'd0;
              state_q   <= ST_WDATA;
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                sda_oen_q <= 1'b1;
                ptr_q     <= ptr_q + 8'd1;
                state_q   <= ST_RDATA_ACK;
              end else begin
                sda_oen_q <= shift_q[6];
                shift_q   <= {shift_q[6:0], 1'b0};
              end
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise && sda_s) begin
              busy_q  <= 1'b0;
              state_q <= ST_WAIT_STOP;
            end else if (scl_fall) begin
              shift_q   <= map_rdata;
              sda_oen_q <= map_rdata[7];
              cnt_q     <= 4'd0;
              state_q   <= ST_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oen   = sda_oen_q;
  assign busy      = busy_q;
  assign i2c_wr    = i2c_wr_q;
  assign i2c_waddr = i2c_waddr_q;
  assign i2c_wdata = i2c_wdata_q;

endmodule

// File: tb/tb_bme280_i2c_slave.sv
// Bench for bme280_i2c_slave: bit-banged I2C master, directed vector table,
// hand-written corner sequences and random traffic against a byte-array model.
module tb_bme280_i2c_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       reg_we = 1'b0;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] reg_wdata = 8'h00;
  logic       sda_oen, i2c_wr, busy;
  logic [7:0] i2c_waddr, i2c_wdata;
  logic       sda_bus;

  assign sda_bus = sda_m & sda_oen;

  always #5 clk = ~clk;

  bme280_i2c_slave dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_m),
    .sda_i     (sda_bus),
    .sda_oen   (sda_oen),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .i2c_wr    (i2c_wr),
    .i2c_waddr (i2c_waddr),
    .i2c_wdata (i2c_wdata),
    .busy      (busy)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  mem_m [256];
  logic [7:0]  ptr_m;
  logic [15:0] wr_log [$];
  logic        low_seen = 1'b0;
  logic        busy_seen = 1'b0;

  always @(negedge clk) begin
    if (i2c_wr) wr_log.push_back({i2c_waddr, i2c_wdata});
    if (!sda_oen) low_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    mem_m[8'hD0] = 8'h60;
    ptr_m = 8'h00;
  endtask

  task automatic qd();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qd();
    scl_m = 1'b1; qd();
    sda_m = 1'b0; qd();
    scl_m = 1'b0; qd();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qd();
    scl_m = 1'b1; qd();
    sda_m = 1'b1; qd();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; qd();
    scl_m = 1'b1; qd(); qd();
    scl_m = 1'b0; qd();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; qd();
    scl_m = 1'b1; qd();
    b = sda_bus; qd();
    scl_m = 1'b0; qd();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic [7:0] v;
    logic       x;
    for (int i = 7; i >= 0; i--) begin
      read_bit(x);
      v[i] = x;
    end
    write_bit(nack);
    b = v;
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    @(posedge clk); #1;
    reg_we = 1'b0;
    mem_m[a] = d;
    $display("[TB] host write [%02h] <= %02h", a, d);
  endtask

  task automatic i2c_write(input logic [7:0] a, input logic [7:0] d [4], input int n);
    logic        ack;
    logic [15:0] exp_q [$];
    wr_log.delete();
    i2c_start();
    write_byte(8'hEC, ack); check("w_addr_ack", ack, 0);
    check("w_busy", busy, 1);
    write_byte(a, ack); check("w_ptr_ack", ack, 0);
    ptr_m = a;
    for (int i = 0; i < n; i++) begin
      write_byte(d[i], ack); check("w_data_ack", ack, 0);
      exp_q.push_back({ptr_m, d[i]});
      mem_m[ptr_m] = d[i];
      ptr_m = ptr_m + 8'd1;
    end
    i2c_stop();
    check("w_pulse_count", wr_log.size(), n);
    for (int i = 0; i < n; i++)
      if (i < wr_log.size()) check("w_pulse_addr_data", wr_log[i], exp_q[i]);
    check("w_busy_after_stop", busy, 0);
    $display("[TB] i2c write [%02h] len %0d", a, n);
  endtask

  task automatic i2c_read(input logic set_ptr, input logic [7:0] a, input int n,
                          output logic [7:0] got [4]);
    logic ack;
    if (set_ptr) begin
      i2c_start();
      write_byte(8'hEC, ack); check("r_waddr_ack", ack, 0);
      write_byte(a, ack); check("r_ptr_ack", ack, 0);
      ptr_m = a;
    end
    i2c_start();
    write_byte(8'hED, ack); check("r_raddr_ack", ack, 0);
    check("r_busy", busy, 1);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, got[i]);
      check("r_data_model", got[i], mem_m[ptr_m]);
      ptr_m = ptr_m + 8'd1;
    end
    check("r_busy_after_nack", busy, 0);
    i2c_stop();
    $display("[TB] i2c read [%02h] len %0d first %02h", ptr_m - n[7:0], n, got[0]);
  endtask

  typedef struct {
    int         kind;   // 0 host write, 1 i2c write, 2 i2c read
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [7:0] got [4];
    logic [7:0] dbuf [4];
    logic       ack;
    int         op, n;
    logic [7:0] a;

    vecs[0] = '{2, 8'hD0, 8'h00, 8'h60};
    vecs[1] = '{1, 8'hF4, 8'h27, 8'h00};
    vecs[2] = '{2, 8'hF4, 8'h00, 8'h27};
    vecs[3] = '{0, 8'hFE, 8'hAA, 8'h00};
    vecs[4] = '{0, 8'hFF, 8'hBB, 8'h00};
    vecs[5] = '{0, 8'h00, 8'hCC, 8'h00};
    vecs[6] = '{2, 8'hE0, 8'h00, 8'h00};
    vecs[7] = '{2, 8'hFF, 8'h00, 8'hBB};

    model_reset();
    repeat (4) @(posedge clk);
    #1;
    check("rst_sda_oen", sda_oen, 1);
    check("rst_busy", busy, 0);
    check("rst_i2c_wr", i2c_wr, 0);
    check("rst_waddr", i2c_waddr, 0);
    check("rst_wdata", i2c_wdata, 0);
    rst_n = 1'b1;
    qd();

    for (int v = 0; v < 8; v++) begin
      case (vecs[v].kind)
        0: host_wr(vecs[v].a, vecs[v].d);
        1: begin
          dbuf[0] = vecs[v].d;
          i2c_write(vecs[v].a, dbuf, 1);
        end
        default: begin
          i2c_read(1'b1, vecs[v].a, 1, got);
          check("vec_read", got[0], vecs[v].exp);
        end
      endcase
    end

    // Burst read across the pointer wrap.
    i2c_read(1'b1, 8'hFE, 3, got);
    check("burst_0", got[0], 8'hAA);
    check("burst_1", got[1], 8'hBB);
    check("burst_2", got[2], 8'hCC);
    i2c_read(1'b0, 8'h00, 1, got);
    check("after_wrap_ptr01", got[0], 8'h00);

    // Foreign address must never be acknowledged.
    low_seen = 1'b0;
    busy_seen = 1'b0;
    i2c_start();
    write_byte(8'hEE, ack); check("foreign_nack", ack, 1);
    write_byte(8'h5A, ack); check("foreign_data_nack", ack, 1);
    i2c_stop();
    check("foreign_sda_low", low_seen, 0);
    check("foreign_busy", busy_seen, 0);
    $display("[TB] foreign address 0x77 ignored");

    // STOP after four data bits aborts the write.
    wr_log.delete();
    i2c_start();
    write_byte(8'hEC, ack); check("abort_addr_ack", ack, 0);
    write_byte(8'hF2, ack); check("abort_ptr_ack", ack, 0);
    ptr_m = 8'hF2;
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_stop();
    check("abort_no_pulse", wr_log.size(), 0);
    $display("[TB] write to F2 aborted after 4 bits");
    i2c_read(1'b1, 8'hF2, 1, got);
    check("abort_f2_unchanged", got[0], 8'h00);

    // Randomised traffic against the model.
    for (int it = 0; it < 20; it++) begin
      op = $urandom_range(0, 3);
      n  = $urandom_range(1, 3);
      a  = ($urandom_range(0, 2) == 0) ? 8'hFD + 8'($urandom_range(0, 2)) : 8'($urandom);
      for (int k = 0; k < 4; k++) dbuf[k] = 8'($urandom);
      case (op)
        0: host_wr(a, dbuf[0]);
        1: i2c_write(a, dbuf, n);
        2: i2c_read(1'b1, a, n, got);
        default: i2c_read(1'b0, a, n, got);
      endcase
    end

    // Reset while the slave is driving a 0 data bit.
    i2c_start();
    write_byte(8'hEC, ack); check("rst_seq_addr_ack", ack, 0);
    write_byte(8'hD0, ack); check("rst_seq_ptr_ack", ack, 0);
    i2c_start();
    write_byte(8'hED, ack); check("rst_seq_raddr_ack", ack, 0);
    check("rd_drive_bit7_zero", sda_oen, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_release", sda_oen, 1);
    check("rst_mid_busy", busy, 0);
    sda_m = 1'b1;
    scl_m = 1'b1;
    qd(); qd();
    rst_n = 1'b1;
    qd();
    $display("[TB] reset asserted mid-read");
    model_reset();
    i2c_read(1'b1, 8'hD0, 1, got);
    check("post_rst_chip_id", got[0], 8'h60);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bme280_i2c_slave.md
Name: bme280_i2c_slave

Overview:
Synthesizable I2C responder that emulates the BME280 sensor's bus interface: the far end of the protocol driven by the i2c_master_top / bme280_i2c_ctrl / bme280_reader chain.
- Holds a 256×8 register map.
- Decodes START, STOP and repeated START, matches the 7-bit slave address, and handles register-pointer writes, data writes and auto-increment burst reads.
- Use: loop-back target on the DE0-CV board and in simulation, so the reader and compensation path can be exercised without a physical sensor.
- A host-side write port lets a stimulus block load calibration and ADC values.

Parameters:
- SLADDR, 7'b111_0110: 7-bit slave address answered.
- CHIP_ID, 8'h60: reset content of register 0xD0.
- NSYNC, 2: synchroniser stages on SCL/SDA inputs.

Ports:
- Clk  in  1  system clock (100 MHz); all logic on rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Scl_i  in  1  SCL line (slave never stretches clock).
- Sda_i  in  1  SDA line.
- Sda_oen  out  1  SDA output enable, active low; pad drives 0 when low, Z when high.
- Reg_we  in  1  host write strobe.
- Reg_addr  in  8  host write address.
- Reg_wdata  in  8  host write data.
- I2c_wr  out  1  one-cycle pulse when an I2C data byte is written to the map.
- I2c_waddr  out  8  address of that byte, valid with I2c_wr.
- I2c_wdata  out  8  data of that byte, valid with I2c_wr.
- Busy  out  1  high from an address-matched START until STOP or a NACK-ended transfer.

Behaviour:
Reset values:
- Sda_oen=1, Busy=0, I2c_wr=0, I2c_waddr=0, I2c_wdata=0.
- Pointer=0, FSM=IDLE.
- Map all 0x00 except 0xD0=CHIP_ID.
- Reset is asynchronous; when asserted mid-transfer, SDA is released at once.

Input conditioning:
- Scl_i and Sda_i pass through NSYNC flops, then one history flop.
- Edge/condition detection therefore lags the pins by NSYNC+1 cycles.
- Bus conditions:
  - START: SDA falling while SCL high.
  - STOP: SDA rising while SCL high.
  - These override every state, same cycle.
- Bits are sampled on the detected SCL rising edge. SDA changes are made on the detected SCL falling edge.

FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- IDLE: START -> ADDR, bit counter cleared.
- ADDR: shift 8 bits MSB-first.
  - On the 8th falling edge, if addr[7:1]==SLADDR: pull Sda_oen=0, set Busy, go to ADDR_ACK.
  - Otherwise go to WAIT_STOP with no ACK.
- ADDR_ACK: on the next falling edge, release.
  - R/W=0 -> PTR.
  - R/W=1 -> RDATA; MSB of map[pointer] is driven in the same cycle.
- PTR: after 8 bits, load pointer, ACK, -> PTR_ACK. After the ACK falling edge -> WDATA.
- WDATA: after 8 bits, write map[pointer], pulse I2c_wr with address and data, ACK, pointer+1, -> WDATA_ACK. After the ACK falling edge -> WDATA.
- RDATA: drive each bit on the falling edge.
  - After the 8th bit falling edge, release SDA and pointer+1; -> RDATA_ACK.
- RDATA_ACK: sample on the rising edge.
  - ACK (0): on the falling edge, drive the next byte -> RDATA.
  - NACK (1): -> WAIT_STOP, Busy=0.
- WAIT_STOP: SDA released. Leave on STOP (-> IDLE) or START (-> ADDR).

Boundary conditions:
- Pointer is 8 bits and wraps 0xFF -> 0x00.
- Repeated START keeps the pointer; this is the register-read sequence.
- STOP or START mid-byte aborts: partial byte discarded, no map write, SDA released.
- Host write and I2C write to the same address in the same cycle: the host value wins, but I2c_wr still pulses.
- Host write to the byte currently being shifted out does not affect it; the read byte is latched at its first bit.

Decomposition:
- bme280_pkg holds:
  - BME280_SLADDR, BME280_CHIP_ID.
  - Register address constants: ID 0xD0, RESET 0xE0, CTRL_HUM 0xF2, STATUS 0xF3, CTRL_MEAS 0xF4, CONFIG 0xF5, PRESS_MSB 0xF7, CALIB00 0x88, CALIB26 0xE1.
  - FSM state encoding.
- Sub-module i2c_slave_regfile: 256×8 map with two write ports (host priority), one async read port and reset preload.
- Synchronisers reuse the existing sync_reg.

Test Plan:
- Reset, then I2C read of 0xD0 (write 0xEC,0xD0; repeated START; 0xED; read 1; NACK) -> byte 0x60, ACK on both address phases, Busy falls after NACK.
- Write 0xEC,0xF4,0x27,STOP -> I2c_wr pulses once with addr 0xF4 / data 0x27; a subsequent read of 0xF4 returns 0x27.
- Host loads 0xFE=0xAA, 0xFF=0xBB, 0x00=0xCC; burst read from 0xFE for 3 bytes -> AA,BB,CC; pointer wraps.
- Address 0xEE (0x77) -> SDA never driven low, FSM returns to IDLE on STOP, Busy stays 0.
- STOP after 4 data bits of a write to 0xF2 -> no I2c_wr pulse, 0xF2 unchanged, next transaction ACKs normally.
- Rst_n asserted during an RDATA bit driving 0 -> Sda_oen=1 immediately; after release, 0xD0 reads 0x60.
